// File: rtl/rtc_bus_sequencer.sv
// Sequencer for the multiplexed address/data bus of the RTC chip: one request becomes a
// full address phase plus data phase, with every bus pin and status flag registered.
module rtc_bus_sequencer #(
   parameter int unsigned T_SETUP = 1,
   parameter int unsigned T_PULSE = 4,
   parameter int unsigned T_HOLD  = 1,
   parameter int unsigned T_GAP   = 2,
   parameter int unsigned CW      = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start_escribe,
   input  logic       start_lee,
   input  logic [7:0] direccion,
   input  logic [7:0] dato_escribir,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   output logic       a_d,
   output logic       cs_n,
   output logic       wr_n,
   output logic       rd_n,
   output logic [7:0] dato_leido,
   output logic       listo,
   output logic       listo_escribe,
   output logic       listo_lee
);

   typedef enum logic [3:0] {
      StIdle,
      StAddrSetup,
      StAddrStrobe,
      StAddrHold,
      StGap,
      StDataSetup,
      StDataStrobe,
      StDataHold,
      StDone
   } state_e;

   // Counters are loaded with duration-1 and the state advances when they reach zero.
   localparam logic [CW-1:0] SetupLd = CW'(T_SETUP - 1);
   localparam logic [CW-1:0] PulseLd = CW'(T_PULSE - 1);
   localparam logic [CW-1:0] HoldLd  = CW'(T_HOLD - 1);
   localparam logic [CW-1:0] GapLd   = CW'(T_GAP - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_dec;
   logic          last;
   logic [7:0]    addr_q, addr_d;
   logic [7:0]    data_q, data_d;
   logic          op_rd_q, op_rd_d;

   logic [7:0]    ad_out_q, ad_out_d;
   logic          ad_oe_q, ad_oe_d;
   logic          a_d_q, a_d_d;
   logic          cs_n_q, cs_n_d;
   logic          wr_n_q, wr_n_d;
   logic          rd_n_q, rd_n_d;
   logic [7:0]    leido_q, leido_d;
   logic          listo_q, listo_d;
   logic          done_w_q, done_w_d;
   logic          done_r_q, done_r_d;

   assign cnt_dec = cnt_q - CW'(1);
   assign last    = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = last ? '0 : cnt_dec;
      addr_d  = addr_q;
      data_d  = data_q;
      op_rd_d = op_rd_q;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            // Write has priority when both requests arrive together.
            if (start_escribe || start_lee) begin
               addr_d  = direccion;
               data_d  = dato_escribir;
               op_rd_d = !start_escribe;
               state_d = StAddrSetup;
               cnt_d   = SetupLd;
            end
         end
         StAddrSetup: if (last) begin
            state_d = StAddrStrobe;
            cnt_d   = PulseLd;
         end
         StAddrStrobe: if (last) begin
            state_d = StAddrHold;
            cnt_d   = HoldLd;
         end
         StAddrHold: if (last) begin
            state_d = StGap;
            cnt_d   = GapLd;
         end
         StGap: if (last) begin
            state_d = StDataSetup;
            cnt_d   = SetupLd;
         end
         StDataSetup: if (last) begin
            state_d = StDataStrobe;
            cnt_d   = PulseLd;
         end
         StDataStrobe: if (last) begin
            state_d = StDataHold;
            cnt_d   = HoldLd;
         end
         StDataHold: if (last) begin
            state_d = StDone;
            cnt_d   = '0;
         end
         StDone: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so that the registered pins line up with it.
   always_comb begin
      ad_out_d = 8'h00;
      ad_oe_d  = 1'b0;
      a_d_d    = 1'b0;
      cs_n_d   = 1'b1;
      wr_n_d   = 1'b1;
      rd_n_d   = 1'b1;
      done_w_d = 1'b0;
      done_r_d = 1'b0;
      listo_d  = (state_d == StIdle);
      unique case (state_d)
         StAddrSetup, StAddrHold: begin
            cs_n_d   = 1'b0;
            ad_oe_d  = 1'b1;
            ad_out_d = addr_d;
         end
         StAddrStrobe: begin
            cs_n_d   = 1'b0;
            ad_oe_d  = 1'b1;
            ad_out_d = addr_d;
            wr_n_d   = 1'b0;
         end
         StDataSetup, StDataHold: begin
            cs_n_d = 1'b0;
            a_d_d  = 1'b1;
            if (!op_rd_d) begin
               ad_oe_d  = 1'b1;
               ad_out_d = data_d;
            end
         end
         StDataStrobe: begin
            cs_n_d = 1'b0;
            a_d_d  = 1'b1;
            if (op_rd_d) begin
               rd_n_d = 1'b0;
            end else begin
               ad_oe_d  = 1'b1;
               ad_out_d = data_d;
               wr_n_d   = 1'b0;
            end
         end
         StDone: begin
            done_w_d = !op_rd_d;
            done_r_d = op_rd_d;
         end
         default: ;
      endcase
   end

   // Sample the chip on the edge that closes the final read-strobe cycle.
   always_comb begin
      leido_d = leido_q;
      if (state_q == StDataStrobe && last && op_rd_q) begin
         leido_d = ad_in;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         addr_q   <= 8'h00;
         data_q   <= 8'h00;
         op_rd_q  <= 1'b0;
         ad_out_q <= 8'h00;
         ad_oe_q  <= 1'b0;
         a_d_q    <= 1'b0;
         cs_n_q   <= 1'b1;
         wr_n_q   <= 1'b1;
         rd_n_q   <= 1'b1;
         leido_q  <= 8'h00;
         listo_q  <= 1'b1;
         done_w_q <= 1'b0;
         done_r_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         op_rd_q  <= op_rd_d;
         ad_out_q <= ad_out_d;
         ad_oe_q  <= ad_oe_d;
         a_d_q    <= a_d_d;
         cs_n_q   <= cs_n_d;
         wr_n_q   <= wr_n_d;
         rd_n_q   <= rd_n_d;
         leido_q  <= leido_d;
         listo_q  <= listo_d;
         done_w_q <= done_w_d;
         done_r_q <= done_r_d;
      end
   end

   assign ad_out        = ad_out_q;
   assign ad_oe         = ad_oe_q;
   assign a_d           = a_d_q;
   assign cs_n          = cs_n_q;
   assign wr_n          = wr_n_q;
   assign rd_n          = rd_n_q;
   assign dato_leido    = leido_q;
   assign listo         = listo_q;
   assign listo_escribe = done_w_q;
   assign listo_lee     = done_r_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: each cycle of a bus operation is checked against a
// hand-written timing table for the default parameters.
module tb_rtc_bus_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start_escribe, start_lee;
   logic [7:0] direccion, dato_escribir, ad_in;
   logic [7:0] ad_out, dato_leido;
   logic       ad_oe, a_d, cs_n, wr_n, rd_n, listo, listo_escribe, listo_lee;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rtc_bus_sequencer dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start_escribe (start_escribe),
      .start_lee     (start_lee),
      .direccion     (direccion),
      .dato_escribir (dato_escribir),
      .ad_in         (ad_in),
      .ad_out        (ad_out),
      .ad_oe         (ad_oe),
      .a_d           (a_d),
      .cs_n          (cs_n),
      .wr_n          (wr_n),
      .rd_n          (rd_n),
      .dato_leido    (dato_leido),
      .listo         (listo),
      .listo_escribe (listo_escribe),
      .listo_lee     (listo_lee)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, " cs_n"},  {7'b0, cs_n},  8'h01);
      chk({tag, " wr_n"},  {7'b0, wr_n},  8'h01);
      chk({tag, " rd_n"},  {7'b0, rd_n},  8'h01);
      chk({tag, " ad_oe"}, {7'b0, ad_oe}, 8'h00);
      chk({tag, " a_d"},   {7'b0, a_d},   8'h00);
      chk({tag, " ad_out"}, ad_out,       8'h00);
      chk({tag, " listo"}, {7'b0, listo}, 8'h01);
      chk({tag, " done_w"}, {7'b0, listo_escribe}, 8'h00);
      chk({tag, " done_r"}, {7'b0, listo_lee},     8'h00);
      chk({tag, " leido"}, dato_leido,    8'h00);
   endtask

   // k = number of rising edges since the accepting edge; sampled on the falling edge.
   // Timeline: 1 addr setup, 2-5 addr strobe, 6 addr hold, 7-8 gap, 9 data setup,
   // 10-13 data strobe, 14 data hold, 15 done, 16 idle.
   task automatic check_cycle(input string tag, input int k, input bit rd,
                              input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] leido_exp);
      logic e_cs, e_wr, e_rd, e_ad, e_oe, e_listo, e_dw, e_dr;
      logic [7:0] e_out;
      string t;
      t       = $sformatf("%s k=%0d", tag, k);
      e_cs    = !((k >= 1 && k <= 6) || (k >= 9 && k <= 14));
      e_wr    = !((k >= 2 && k <= 5) || (!rd && k >= 10 && k <= 13));
      e_rd    = !(rd && k >= 10 && k <= 13);
      e_ad    = (k >= 9 && k <= 14);
      e_oe    = (k >= 1 && k <= 6) || (!rd && k >= 9 && k <= 14);
      e_out   = (k <= 6) ? a : d;
      e_listo = (k >= 16);
      e_dw    = !rd && k == 15;
      e_dr    = rd && k == 15;
      chk({t, " cs_n"},  {7'b0, cs_n},  {7'b0, e_cs});
      chk({t, " wr_n"},  {7'b0, wr_n},  {7'b0, e_wr});
      chk({t, " rd_n"},  {7'b0, rd_n},  {7'b0, e_rd});
      chk({t, " a_d"},   {7'b0, a_d},   {7'b0, e_ad});
      chk({t, " ad_oe"}, {7'b0, ad_oe}, {7'b0, e_oe});
      if (e_oe) chk({t, " ad_out"}, ad_out, e_out);
      chk({t, " listo"},  {7'b0, listo},         {7'b0, e_listo});
      chk({t, " done_w"}, {7'b0, listo_escribe}, {7'b0, e_dw});
      chk({t, " done_r"}, {7'b0, listo_lee},     {7'b0, e_dr});
      chk({t, " leido"},  dato_leido,            leido_exp);
   endtask

   initial begin
      // Reset with random inputs.
      reset_n       = 1'b0;
      start_escribe = 1'b0;
      start_lee     = 1'b0;
      direccion     = 8'h00;
      dato_escribir = 8'h00;
      ad_in         = 8'h00;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_reset_values($sformatf("reset%0d", i));
         start_escribe = 1'($urandom);
         start_lee     = 1'($urandom);
         direccion     = 8'($urandom);
         dato_escribir = 8'($urandom);
         ad_in         = 8'($urandom);
      end
      @(negedge clk);
      start_escribe = 1'b0;
      start_lee     = 1'b0;
      ad_in         = 8'h33;
      reset_n       = 1'b1;
      @(negedge clk);
      check_reset_values("idle");

      // Write 0xD2 to 0x21.
      start_escribe = 1'b1;
      direccion     = 8'h21;
      dato_escribir = 8'hD2;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         check_cycle("write", k, 1'b0, 8'h21, 8'hD2, 8'h00);
         if (k == 1) begin
            start_escribe = 1'b0;
            direccion     = 8'h00;
            dato_escribir = 8'h00;
         end
      end

      // Read from 0xF1; the chip returns 0x5A only during the data strobe.
      start_lee     = 1'b1;
      direccion     = 8'hF1;
      dato_escribir = 8'h77;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         check_cycle("read", k, 1'b1, 8'hF1, 8'h00, (k >= 14) ? 8'h5A : 8'h00);
         if (k == 1) start_lee = 1'b0;
         ad_in = (k >= 10 && k <= 13) ? 8'h5A : 8'h33;
      end

      // Both requests together: the write wins.
      start_escribe = 1'b1;
      start_lee     = 1'b1;
      direccion     = 8'h44;
      dato_escribir = 8'h99;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         check_cycle("both", k, 1'b0, 8'h44, 8'h99, 8'h5A);
         if (k == 1) begin
            start_escribe = 1'b0;
            start_lee     = 1'b0;
         end
      end

      // Read request in the middle of a write is dropped.
      start_escribe = 1'b1;
      direccion     = 8'h10;
      dato_escribir = 8'h20;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         check_cycle("busy", k, 1'b0, 8'h10, 8'h20, 8'h5A);
         if (k == 1) start_escribe = 1'b0;
         start_lee = (k == 5 || k == 9);
         if (k == 5) direccion = 8'hEE;
      end

      // Reset during the data strobe of a read.
      start_lee = 1'b1;
      direccion = 8'hF1;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         check_cycle("rstmid", k, 1'b1, 8'hF1, 8'h00, 8'h5A);
         if (k == 1) start_lee = 1'b0;
      end
      ad_in   = 8'hA5;
      reset_n = 1'b0;
      #1;
      check_reset_values("rstmid async");
      @(negedge clk);
      check_reset_values("rstmid held");
      reset_n = 1'b1;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         check_reset_values($sformatf("rstmid after%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
